data_tcm_responder: RTL and testbench
=====================================

// Module: data_tcm_responder
// PURPOSE
//  Responder end of the core's load/store interface: accepts LSU requests issued in MEMPREP and returns
//  load data / store acks consumed in MEMEX. Owns a byte-enabled data TCM, load sign/zero extension,
//  store lane steering, configurable wait states and a one-entry response hold for MEMEX stalls.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words in the TCM (power of 2)
//  BASE_ADDR    32'h0001_0000 byte address of word 0; must be DEPTH_WORDS*4 aligned
//  WAIT_STATES  0             extra cycles between accept and response (0..7)
// PORTS
//  clk           input   1   core clock, all state on rising edge
//  rst           input   1   asynchronous reset, active-low
//  req_valid     input   1   LSU request present
//  req_ready     output  1   responder accepts request this cycle
//  req_we        input   1   1 = store, 0 = load
//  req_size      input   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  input   1   load zero-extends (LBU/LHU) when 1
//  req_addr      input   32  byte address
//  req_wdata     input   32  store data, right-aligned (rs2)
//  rsp_valid     output  1   response present
//  rsp_ready     input   1   MEMEX not stalled; response consumed
//  rsp_rdata     output  32  extended load data; 0 for stores and errors
//  rsp_err       output  1   misaligned, out-of-range or illegal-size access
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, wait counter 0, req_ready=0 while asserted, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0. TCM contents not reset. Reset mid-transaction drops it; no response follows.
//  Accept: handshake when req_valid & req_ready. req_ready = (state==IDLE) | (state==RESP & rsp_ready).
//  FSM: IDLE -accept-> WAIT if WAIT_STATES>0 else RESP. WAIT counts WAIT_STATES cycles, then RESP.
//   RESP: rsp_valid=1; outputs held stable until rsp_ready. On rsp_ready: accept-in-same-cycle -> WAIT/RESP
//   for new request, else IDLE. WAIT_STATES=0 gives 1-cycle latency and full back-to-back throughput.
//  Latency: response visible exactly 1+WAIT_STATES cycles after accept edge when rsp_ready held high.
//  Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0;
//   addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4). Error -> no TCM write, rsp_err=1, rsp_rdata=0.
//  Store: word index = (addr-BASE_ADDR)[..:2]; byte: be=1<<addr[1:0], data replicated x4;
//   half: be=3<<addr[1:0], data replicated x2; word: be=4'hF. Write occurs at accept edge;
//   store response rsp_rdata=0, rsp_err=0.
//  Load: TCM read issued at accept edge (sync read); data captured into response register before RESP;
//   select lane by addr[1:0], sign-extend from bit 7/15 unless req_unsigned. Word ignores req_unsigned.
//  Store then load same address back-to-back: load returns new data (write precedes read at same
//   edge: TCM is write-first).
//  rsp_ready low in RESP: no new accept, response bits unchanged; req_ready=0.
//  rsp_ready while rsp_valid=0 ignored. Request fields only sampled at accept.
// STRUCTURE
//  Shared package topaz_pkg: mem_size_t enum (MEM_BYTE/MEM_HALF/MEM_WORD), lsu_state_t
//   (IDLE/WAIT/RESP), function load_extend(word, offset, size, unsigned).
//  Sub-module tcm_sram_be: DEPTH_WORDS x 32 sync-read, write-first, 4-bit byte enable single port.
//  Responder owns FSM, wait counter, error check, lane steering, response register.
// TESTING
//  1 Reset: rst=0 mid-RESP -> rsp_valid=0, rsp_rdata=0 immediately; after release req_ready=1 next cycle.
//  2 SW 0xDEADBEEF @0x0001_0000, LB @0x0001_0003 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @+2 -> 0xFFFFDEAD.
//  3 SB 0x12 @0x0001_0005 over word 0 -> LW @0x0001_0004 returns 0x00001200 (prior zeros).
//  4 LW @0x0001_0002 -> rsp_err=1, rdata=0; SW @BASE+DEPTH_WORDS*4 -> err=1, memory unchanged.
//  5 WAIT_STATES=2: LW accepted cycle t -> rsp_valid first high t+3; req_ready low t+1..t+2.
//  6 rsp_ready=0 for 4 cycles in RESP -> rsp_rdata stable, req_ready=0; back-to-back SW/LW same addr
//    with rsp_ready=1 -> one response per cycle, LW returns stored value.

Source files
------------

// File: rtl/topaz_pkg.sv
// Shared load/store types for the TCM responder: access size, responder FSM state,
// and the load-lane extraction/extension helper.
package topaz_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } lsu_state_t;

   // Pick the addressed lane out of a TCM word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input mem_size_t   size,
                                               input logic        is_unsigned);
      logic [31:0] sh;
      sh = word >> {offset, 3'b000};
      case (size)
         MEM_BYTE: load_extend = {{24{sh[7] & ~is_unsigned}}, sh[7:0]};
         MEM_HALF: load_extend = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
         default:  load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/tcm_sram_be.sv
// Single-port data TCM, one byte array per lane: synchronous read, byte-enabled
// write, write-first on a write to the addressed lane.
module tcm_sram_be #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk_i) begin
         if (en_i) begin
            if (we_i && be_i[l]) begin
               mem_q[addr_i] <= wdata_i[8*l +: 8];
               rd_q          <= wdata_i[8*l +: 8];
            end else begin
               rd_q <= mem_q[addr_i];
            end
         end
      end

      assign rdata_o[8*l +: 8] = rd_q;
   end

endmodule

// File: rtl/data_tcm_responder.sv
// LSU responder: accepts load/store requests, owns the data TCM, applies wait
// states and holds one response until MEMEX consumes it.
module data_tcm_responder
   import topaz_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
   localparam logic [2:0]  WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
   localparam lsu_state_t  FIRST   = (WAIT_STATES > 0) ? WAIT : RESP;

   lsu_state_t  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ld_q, err_q, uns_q;
   logic [1:0]  off_q;
   mem_size_t   size_q;

   logic        accept, acc_err;
   mem_size_t   size;
   logic [31:0] rel, wdata, tcm_rdata;
   logic [3:0]  be;

   assign req_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
   assign accept      = req_valid_i & req_ready_o;
   assign size        = mem_size_t'(req_size_i);
   // Unsigned offset from the base folds the below-base case into the range compare.
   assign rel         = req_addr_i - BASE_ADDR;

   always_comb begin
      acc_err = (rel >= SPAN);
      be      = 4'hF;
      wdata   = req_wdata_i;
      case (size)
         MEM_BYTE: begin
            be    = 4'b0001 << req_addr_i[1:0];
            wdata = {4{req_wdata_i[7:0]}};
         end
         MEM_HALF: begin
            be      = 4'b0011 << req_addr_i[1:0];
            wdata   = {2{req_wdata_i[15:0]}};
            acc_err = acc_err | req_addr_i[0];
         end
         MEM_WORD: acc_err = acc_err | (req_addr_i[1:0] != 2'b00);
         default:  acc_err = 1'b1;
      endcase
   end

   // The TCM output register doubles as the held load data: it only changes on an
   // accept, which can never happen while a response is still pending.
   tcm_sram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_tcm (
      .clk_i   (clk_i),
      .en_i    (accept & ~acc_err),
      .we_i    (req_we_i),
      .be_i    (be),
      .addr_i  (rel[AW+1:2]),
      .wdata_i (wdata),
      .rdata_o (tcm_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = FIRST;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == WS_LAST) state_d = RESP;
         end
         RESP: if (rsp_ready_i) begin
            state_d = accept ? FIRST : IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ld_q    <= 1'b0;
         err_q   <= 1'b0;
         uns_q   <= 1'b0;
         off_q   <= '0;
         size_q  <= MEM_WORD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            ld_q   <= ~req_we_i;
            err_q  <= acc_err;
            uns_q  <= req_unsigned_i;
            off_q  <= req_addr_i[1:0];
            size_q <= size;
         end
      end
   end

   assign rsp_valid_o = (state_q == RESP);
   assign rsp_err_o   = rsp_valid_o & err_q;
   assign rsp_rdata_o = (rsp_valid_o & ld_q & ~err_q) ?
                        load_extend(tcm_rdata, off_q, size_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_data_tcm_responder.sv
// Scoreboarded bench for data_tcm_responder: a zero-wait instance for function
// and throughput, a two-wait-state instance for latency.
module tb_data_tcm_responder;
   import topaz_pkg::*;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] TOP   = BASE + DEPTH * 4;

   logic clk = 1'b0, rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 1;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        w_req_valid = 0, w_req_we = 0, w_rsp_ready = 1;
   logic [1:0]  w_req_size = 0;
   logic [31:0] w_req_addr = 0, w_req_wdata = 0;
   logic        w_req_ready, w_rsp_valid, w_rsp_err;
   logic [31:0] w_rsp_rdata;

   data_tcm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err));

   data_tcm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_ws (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
      .req_we_i(w_req_we), .req_size_i(w_req_size), .req_unsigned_i(1'b0),
      .req_addr_i(w_req_addr), .req_wdata_i(w_req_wdata), .rsp_valid_o(w_rsp_valid),
      .rsp_ready_i(w_rsp_ready), .rsp_rdata_o(w_rsp_rdata), .rsp_err_o(w_rsp_err));

   typedef struct packed { logic err; logic [31:0] rdata; } exp_t;
   exp_t exp_q[$];
   int n_cmp = 0, n_bad = 0;

   // Scoreboard: every consumed response is checked against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rsp_valid && rsp_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_extra: got err=%0b rdata=%08h, expected no response", rsp_err, rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== e) begin
               n_bad++;
               $display("FAIL sb_rsp: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                        rsp_err, rsp_rdata, e.err, e.rdata);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic err, input logic [31:0] rd);
      logic acc;
      acc = 1'b0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      for (int k = 0; k < 50 && !acc; k++) begin
         #1 acc = req_ready;
         @(posedge clk);
         if (!acc) @(negedge clk);
      end
      n_cmp++;
      if (!acc) begin
         n_bad++;
         $display("FAIL accept_timeout: addr=%08h never accepted, expected accept", a);
      end else begin
         exp_q.push_back(exp_t'({err, rd}));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
         @(negedge clk); #3;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_ni = 0; rsp_ready = 1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata, w_req_ready, w_rsp_valid} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got rdy=%0b vld=%0b err=%0b rdata=%08h, expected all 0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk); rst_ni = 1;
      @(negedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL ready_after_reset: got %0b, expected 1", req_ready);
      end
      issue(1, 2'b10, 0, BASE + 16, 32'h89AB_CDEF, 0, 32'h0);
      idle();
      drain();
      rsp_ready = 0;
      issue(0, 2'b10, 0, BASE + 16, 32'h0, 0, 32'h89AB_CDEF);
      idle();
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h89AB_CDEF) begin
         n_bad++; $display("FAIL resp_before_reset: got vld=%0b rdata=%08h, expected 1/89abcdef", rsp_valid, rsp_rdata);
      end
      rst_ni = 0;
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== '0) begin
         n_bad++; $display("FAIL reset_mid_resp: got vld=%0b rdata=%08h rdy=%0b, expected 0", rsp_valid, rsp_rdata, req_ready);
      end
      exp_q.delete();
      @(negedge clk); rst_ni = 1; rsp_ready = 1;
      @(negedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL after_reset_drop: got rdy=%0b vld=%0b, expected 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_load_extend();
      issue(1, 2'b10, 0, BASE,     32'hDEAD_BEEF, 0, 32'h0);
      issue(0, 2'b00, 0, BASE + 3, 32'h0, 0, 32'hFFFF_FFDE);
      issue(0, 2'b00, 1, BASE + 3, 32'h0, 0, 32'h0000_00DE);
      issue(0, 2'b01, 0, BASE + 2, 32'h0, 0, 32'hFFFF_DEAD);
      issue(0, 2'b01, 1, BASE + 2, 32'h0, 0, 32'h0000_DEAD);
      issue(0, 2'b00, 0, BASE + 1, 32'h0, 0, 32'hFFFF_FFBE);
      issue(0, 2'b01, 1, BASE,     32'h0, 0, 32'h0000_BEEF);
      issue(0, 2'b10, 1, BASE,     32'h0, 0, 32'hDEAD_BEEF);
      idle();
      drain();
   endtask

   task automatic test_store_lanes();
      issue(1, 2'b10, 0, BASE + 4, 32'h0,         0, 32'h0);
      issue(1, 2'b00, 0, BASE + 5, 32'hFFFF_FF12, 0, 32'h0);
      issue(0, 2'b10, 0, BASE + 4, 32'h0,         0, 32'h0000_1200);
      issue(1, 2'b01, 0, BASE + 6, 32'hAAAA_5678, 0, 32'h0);
      issue(0, 2'b10, 0, BASE + 4, 32'h0,         0, 32'h5678_1200);
      issue(1, 2'b00, 0, BASE + 4, 32'h0000_0080, 0, 32'h0);
      issue(0, 2'b00, 0, BASE + 4, 32'h0,         0, 32'hFFFF_FF80);
      issue(0, 2'b00, 1, BASE + 4, 32'h0,         0, 32'h0000_0080);
      idle();
      drain();
   endtask

   task automatic test_errors();
      issue(0, 2'b10, 0, BASE + 2,   32'h0,         1, 32'h0);
      issue(1, 2'b10, 0, TOP,        32'h0000_0055, 1, 32'h0);
      issue(0, 2'b10, 0, BASE,       32'h0,         0, 32'hDEAD_BEEF);
      issue(0, 2'b01, 0, BASE + 1,   32'h0,         1, 32'h0);
      issue(0, 2'b11, 0, BASE,       32'h0,         1, 32'h0);
      issue(0, 2'b00, 0, BASE - 1,   32'h0,         1, 32'h0);
      issue(1, 2'b10, 0, TOP - 4,    32'h7F00_0000, 0, 32'h0);
      issue(0, 2'b00, 0, TOP - 1,    32'h0,         0, 32'h0000_007F);
      idle();
      drain();
   endtask

   task automatic test_wait_states();
      bit seen;
      seen = 0;
      @(negedge clk);
      w_req_valid = 1; w_req_we = 1; w_req_size = 2'b10; w_req_addr = BASE + 32'h40; w_req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      w_req_valid = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         #1 seen = w_rsp_valid;
         @(negedge clk);
      end
      n_cmp++;
      if (!seen || w_rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL ws_store_rsp: got seen=%0b err=%0b, expected 1/0", seen, w_rsp_err);
      end
      w_req_valid = 1; w_req_we = 0;
      #1;
      n_cmp++;
      if (w_req_ready !== 1'b1) begin
         n_bad++; $display("FAIL ws_ready_idle: got %0b, expected 1", w_req_ready);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         w_req_valid = 0;
         #1;
         n_cmp++;
         if (k < 3 && {w_rsp_valid, w_req_ready} !== 2'b00) begin
            n_bad++; $display("FAIL ws_wait_t+%0d: got vld=%0b rdy=%0b, expected 0/0", k, w_rsp_valid, w_req_ready);
         end else if (k == 3 && (w_rsp_valid !== 1'b1 || w_rsp_rdata !== 32'hCAFE_F00D)) begin
            n_bad++; $display("FAIL ws_resp_t+3: got vld=%0b rdata=%08h, expected 1/cafef00d", w_rsp_valid, w_rsp_rdata);
         end
      end
   endtask

   task automatic test_stall_back_to_back();
      longint t0, t1;
      issue(1, 2'b10, 0, BASE + 8, 32'h0BAD_CAFE, 0, 32'h0);
      idle();
      drain();
      rsp_ready = 0;
      issue(0, 2'b10, 0, BASE + 8, 32'h0, 0, 32'h0BAD_CAFE);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid = 1; req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = BASE;
         #1;
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_CAFE || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_hold_%0d: got vld=%0b rdata=%08h rdy=%0b, expected 1/0badcafe/0",
                              k, rsp_valid, rsp_rdata, req_ready);
         end
      end
      rsp_ready = 1;
      exp_q.push_back(exp_t'({1'b0, 32'hDEAD_BEEF}));
      @(posedge clk);
      idle();
      drain();
      issue(1, 2'b10, 0, BASE + 12, 32'h1122_3344, 0, 32'h0);
      t0 = $time;
      issue(0, 2'b10, 0, BASE + 12, 32'h0,         0, 32'h1122_3344);
      issue(1, 2'b10, 0, BASE + 12, 32'h5566_7788, 0, 32'h0);
      issue(0, 2'b10, 0, BASE + 12, 32'h0,         0, 32'h5566_7788);
      issue(0, 2'b01, 0, BASE + 14, 32'h0,         0, 32'h0000_5566);
      t1 = $time;
      idle();
      drain();
      n_cmp++;
      if (t1 - t0 != 40) begin
         n_bad++; $display("FAIL b2b_throughput: got %0d time units for 4 accepts, expected 40", t1 - t0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_extend();
      test_store_lanes();
      test_errors();
      test_wait_states();
      test_stall_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
